// File: rtl/ysyx_25050147_muldiv.sv
// Iterative RV32M multiply/divide unit.
// Shift-add multiplier and restoring divider, one bit per cycle on operand
// magnitudes, with the sign fixed up as the last iteration retires.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a request; in_ready high
// CALC  | iterating; cnt_q counts remaining bits down to 0
// DONE  | result_q held with out_valid high until out_ready
module ysyx_25050147_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept;
  logic              sgn1_in, sgn2_in, s1_in, s2_in, neg_in;
  logic [XLEN-1:0]   mag1_in, mag2_in;
  logic              div_zero_in, div_ovf_in, fast_in;
  logic [XLEN-1:0]   fast_res_in;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  // Register file: state and datapath, synchronous reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  // Request decode: operand signs, magnitudes and the divide special cases
  always_comb begin
    accept      = in_valid & in_ready & ~flush;
    sgn1_in     = (op == OP_MULH) | (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM);
    sgn2_in     = (op == OP_MULH) | (op == OP_DIV) | (op == OP_REM);
    s1_in       = sgn1_in & src1[XLEN-1];
    s2_in       = sgn2_in & src2[XLEN-1];
    mag1_in     = s1_in ? -src1 : src1;
    mag2_in     = s2_in ? -src2 : src2;
    // a remainder takes the dividend's sign, everything else the xor
    neg_in      = (op == OP_REM) ? s1_in : (s1_in ^ s2_in);
    div_zero_in = (src2 == '0);
    div_ovf_in  = ((op == OP_DIV) | (op == OP_REM)) &
                  (src1 == {1'b1, {(XLEN-1){1'b0}}}) & (src2 == '1);
    fast_in     = op[2] & (div_zero_in | div_ovf_in);
    if (op[1]) fast_res_in = div_zero_in ? src1 : '0;
    else       fast_res_in = div_zero_in ? '1 : src1;
  end

  // One iteration step plus the sign-corrected final result
  always_comb begin
    // multiply: {hi,lo} shifts right, adding the multiplicand on a set lsb
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    // divide: {hi,lo} shifts left, quotient bits enter at lo lsb
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, b_q};
    div_ge   = ~div_diff[XLEN];
    if (op_q[2]) begin
      step_hi = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], div_ge};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod_fix = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    quo_fix  = neg_q ? -step_lo : step_lo;
    rem_fix  = neg_q ? -step_hi : step_hi;
    if (op_q[2])              final_res = op_q[1] ? rem_fix : quo_fix;
    else if (op_q == OP_MUL)  final_res = prod_fix[XLEN-1:0];
    else                      final_res = prod_fix[2*XLEN-1:XLEN];
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid & in_ready) state_d = fast_in ? S_DONE : S_CALC;
      S_CALC:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Datapath next values: load on accept, iterate in CALC, retire at count 0
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;
    if (flush) begin
      cnt_d = '0;
    end else if (accept) begin
      op_d  = op;
      neg_d = neg_in;
      cnt_d = CNT_W'(XLEN - 1);
      hi_d  = '0;
      lo_d  = op[2] ? mag1_in : mag2_in;
      b_d   = op[2] ? mag2_in : mag1_in;
      if (fast_in) result_d = fast_res_in;
    end else if (state_q == S_CALC) begin
      hi_d = step_hi;
      lo_d = step_lo;
      if (cnt_q == '0) result_d = final_res;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Handshake outputs decoded from registered state only
  always_comb begin
    in_ready  = (state_q == S_IDLE) & ~rst;
    out_valid = (state_q == S_DONE);
    result    = result_q;
  end

endmodule

// File: tb/tb_ysyx_25050147_muldiv.sv
// Directed bench for the multiply/divide unit: a 32-bit and a 16-bit instance
// share clock and reset; a scoreboard fed by an arithmetic reference checks
// every valid result, directed vectors carry hand-computed values.
module tb_ysyx_25050147_muldiv;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        flush_a = 1'b0, iv_a = 1'b0, ordy_a = 1'b0;
  logic        ir_a, ov_a;
  logic [2:0]  op_a = '0;
  logic [31:0] s1_a = '0, s2_a = '0, res_a;

  logic        flush_b = 1'b0, iv_b = 1'b0, ordy_b = 1'b0;
  logic        ir_b, ov_b;
  logic [2:0]  op_b = '0;
  logic [15:0] s1_b = '0, s2_b = '0, res_b;

  int n_checks = 0;
  int n_err    = 0;

  logic [63:0] q_a[$];
  logic [63:0] q_b[$];

  ysyx_25050147_muldiv #(.XLEN(32)) dut_a (
    .clk(clk), .rst(rst), .flush(flush_a), .in_valid(iv_a), .in_ready(ir_a),
    .op(op_a), .src1(s1_a), .src2(s2_a), .out_valid(ov_a), .out_ready(ordy_a),
    .result(res_a)
  );

  ysyx_25050147_muldiv #(.XLEN(16)) dut_b (
    .clk(clk), .rst(rst), .flush(flush_b), .in_valid(iv_b), .in_ready(ir_b),
    .op(op_b), .src1(s1_b), .src2(s2_b), .out_valid(ov_b), .out_ready(ordy_b),
    .result(res_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic on w-bit operands using 64-bit integers
  function automatic logic [63:0] model(input int w, input logic [2:0] o,
                                        input logic [63:0] a, input logic [63:0] b);
    longint mask, half, ua, ub, sa, sb, r;
    logic [63:0] up;
    mask = (longint'(1) <<< w) - 1;
    half = longint'(1) <<< (w - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua ^ half) - half;
    sb   = (ub ^ half) - half;
    up   = 64'(ua * ub);
    case (o)
      3'd0: r = ua * ub;
      3'd1: r = (sa * sb) >>> w;
      3'd2: r = (sa * ub) >>> w;
      3'd3: r = longint'(up >> w);
      3'd4: r = (ub == 0) ? -1 : ((sa == -half && sb == -1) ? sa : sa / sb);
      3'd5: r = (ub == 0) ? -1 : ua / ub;
      3'd6: r = (ub == 0) ? sa : ((sa == -half && sb == -1) ? 0 : sa % sb);
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return 64'(r & mask);
  endfunction

  // Scoreboard: queue expectations on accept, compare whenever out_valid
  always @(negedge clk) begin
    if (rst) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (ov_a) begin
        chk("sb32_pending", 64'(q_a.size() > 0), 64'd1);
        if (q_a.size() > 0) chk("sb32_result", {32'h0, res_a}, q_a[0]);
      end
      if (flush_a) q_a.delete();
      else begin
        if (ov_a && ordy_a && q_a.size() > 0) void'(q_a.pop_front());
        if (iv_a && ir_a) q_a.push_back(model(32, op_a, {32'h0, s1_a}, {32'h0, s2_a}));
      end
      if (ov_b) begin
        chk("sb16_pending", 64'(q_b.size() > 0), 64'd1);
        if (q_b.size() > 0) chk("sb16_result", {48'h0, res_b}, q_b[0]);
      end
      if (flush_b) q_b.delete();
      else begin
        if (ov_b && ordy_b && q_b.size() > 0) void'(q_b.pop_front());
        if (iv_b && ir_b) q_b.push_back(model(16, op_b, {48'h0, s1_b}, {48'h0, s2_b}));
      end
    end
  end

  function automatic logic sel_ov(input int w);
    return (w == 32) ? ov_a : ov_b;
  endfunction
  function automatic logic sel_ir(input int w);
    return (w == 32) ? ir_a : ir_b;
  endfunction
  function automatic logic [31:0] sel_res(input int w);
    return (w == 32) ? res_a : {16'h0, res_b};
  endfunction

  // Issue one request, measure latency, optionally stall in DONE, then accept
  task automatic run_op(input int w, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int lat_exp, input int hold, input string name);
    int lat;
    chk({name, "_in_ready"}, 64'(sel_ir(w)), 64'd1);
    if (w == 32) begin iv_a = 1'b1; op_a = o; s1_a = a; s2_a = b; end
    else begin iv_b = 1'b1; op_b = o; s1_b = a[15:0]; s2_b = b[15:0]; end
    @(posedge clk); #1;
    iv_a = 1'b0; iv_b = 1'b0;
    if (w == 32) begin s1_a = $urandom; s2_a = $urandom; op_a = 3'($urandom); end
    else begin s1_b = 16'($urandom); s2_b = 16'($urandom); op_b = 3'($urandom); end
    lat = 1;
    while (!sel_ov(w) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(lat_exp));
    chk({name, "_result"}, {32'h0, sel_res(w)}, {32'h0, exp});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, "_hold_result"}, {32'h0, sel_res(w)}, {32'h0, exp});
      chk({name, "_hold_valid"}, 64'(sel_ov(w)), 64'd1);
      chk({name, "_hold_in_ready"}, 64'(sel_ir(w)), 64'd0);
    end
    if (w == 32) ordy_a = 1'b1; else ordy_b = 1'b1;
    #1;
    chk({name, "_hs_in_ready"}, 64'(sel_ir(w)), 64'd0);
    @(posedge clk); #1;
    ordy_a = 1'b0; ordy_b = 1'b0;
    chk({name, "_after_valid"}, 64'(sel_ov(w)), 64'd0);
    chk({name, "_after_in_ready"}, 64'(sel_ir(w)), 64'd1);
  endtask

  task automatic expect_quiet(input string name);
    int seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ov_a) seen++;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid32", 64'(ov_a), 64'd0);
    chk("rst_result32", {32'h0, res_a}, 64'd0);
    chk("rst_in_ready32", 64'(ir_a), 64'd0);
    chk("rst_valid16", 64'(ov_b), 64'd0);
    chk("rst_result16", {48'h0, res_b}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready32", 64'(ir_a), 64'd1);
    chk("post_rst_in_ready16", 64'(ir_b), 64'd1);

    run_op(32, 3'b000, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0, "mul_7_m3");
    run_op(32, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0, "mulhu_max");
    run_op(32, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0, "mulh_min");
    run_op(32, 3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33, 0, "mulhsu_m1_2");
    run_op(32, 3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 33, 0, "mulh_max");
    run_op(32, 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 0, "mulhsu_min");
    run_op(32, 3'b101, 32'd100,      32'd7,        32'd14,       33, 0, "divu_100_7");
    run_op(32, 3'b111, 32'd100,      32'd7,        32'd2,        33, 0, "remu_100_7");
    run_op(32, 3'b100, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 33, 0, "div_m100_7");
    run_op(32, 3'b110, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 33, 0, "rem_m100_7");
    run_op(32, 3'b100, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFE, 33, 0, "div_7_m3");
    run_op(32, 3'b110, 32'd7,        32'hFFFFFFFD, 32'd1,        33, 0, "rem_7_m3");
    run_op(32, 3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  0, "div_by0");
    run_op(32, 3'b110, 32'h1234,     32'd0,        32'h1234,     1,  0, "rem_by0");
    run_op(32, 3'b101, 32'd9,        32'd0,        32'hFFFFFFFF, 1,  0, "divu_by0");
    run_op(32, 3'b111, 32'h55,       32'd0,        32'h55,       1,  0, "remu_by0");
    run_op(32, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0, "div_ovf");
    run_op(32, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1,  0, "rem_ovf");
    run_op(32, 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h0,        33, 0, "divu_no_ovf");
    run_op(32, 3'b101, 32'd1000,     32'd10,       32'd100,      33, 5, "divu_hold");

    // flush at CALC cycle 10 with a competing request
    chk("flush_calc_in_ready", 64'(ir_a), 64'd1);
    iv_a = 1'b1; op_a = 3'b000; s1_a = 32'h1111; s2_a = 32'h2222;
    @(posedge clk); #1;
    iv_a = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush_a = 1'b1; iv_a = 1'b1; op_a = 3'b101; s1_a = 32'd50; s2_a = 32'd5;
    @(posedge clk); #1;
    flush_a = 1'b0; iv_a = 1'b0;
    chk("flush_calc_valid", 64'(ov_a), 64'd0);
    chk("flush_calc_in_ready", 64'(ir_a), 64'd1);
    chk("flush_calc_result_kept", {32'h0, res_a}, 64'd100);
    expect_quiet("flush_calc_no_out");

    // flush in IDLE beats a simultaneous accept
    iv_a = 1'b1; flush_a = 1'b1; op_a = 3'b000; s1_a = 32'd3; s2_a = 32'd3;
    @(posedge clk); #1;
    iv_a = 1'b0; flush_a = 1'b0;
    chk("flush_idle_in_ready", 64'(ir_a), 64'd1);
    expect_quiet("flush_idle_no_out");

    // reset in the middle of a divide
    iv_a = 1'b1; op_a = 3'b100; s1_a = 32'hFFFFFF9C; s2_a = 32'd7;
    @(posedge clk); #1;
    iv_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_calc_valid", 64'(ov_a), 64'd0);
    chk("rst_calc_result", {32'h0, res_a}, 64'd0);
    chk("rst_calc_in_ready", 64'(ir_a), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_calc_in_ready_rel", 64'(ir_a), 64'd1);
    expect_quiet("rst_calc_no_out");
    run_op(32, 3'b011, 32'h10000, 32'h10000, 32'h1, 33, 0, "mulhu_after_rst");

    // divide cases on the 16-bit instance
    run_op(16, 3'b101, 32'd100,  32'd7,    32'd14,   17, 0, "x16_divu");
    run_op(16, 3'b111, 32'd100,  32'd7,    32'd2,    17, 0, "x16_remu");
    run_op(16, 3'b100, 32'hFF9C, 32'd7,    32'hFFF2, 17, 0, "x16_div");
    run_op(16, 3'b110, 32'hFF9C, 32'd7,    32'hFFFE, 17, 2, "x16_rem");
    run_op(16, 3'b100, 32'd5,    32'd0,    32'hFFFF, 1,  0, "x16_div_by0");
    run_op(16, 3'b110, 32'h1234, 32'd0,    32'h1234, 1,  0, "x16_rem_by0");
    run_op(16, 3'b100, 32'h8000, 32'hFFFF, 32'h8000, 1,  0, "x16_div_ovf");
    run_op(16, 3'b110, 32'h8000, 32'hFFFF, 32'h0,    1,  0, "x16_rem_ovf");

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
